// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing for the 5-stage pipeline -- stage enables, flush/bubble,
// ID-stage forwarding selects, a data-memory wait watchdog and saturating debug counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       exe_rn,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic             exe_is_beq,
  input  logic             exe_is_bne,
  input  logic             exe_is_jump,
  input  logic             exe_zero,
  input  logic [4:0]       mem_rn,
  input  logic             mem_wreg,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             pc_sel_branch,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_MEM_WAIT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_mem_err, w_mem_err_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_wait_cnt;
  logic             w_take, w_lu, w_mwait, w_freeze;
  logic             w_inc_stall, w_inc_flush, w_inc_wait;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && !(&v)) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    else             return v;
  endfunction

  // EXE result beats MEM result; a load still in EXE has no data yet, and r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic e_w, input logic e_ld,
                                         input logic [4:0] e_rn, input logic m_w, input logic [4:0] m_rn);
    if (e_w && !e_ld && (e_rn != 5'd0) && (e_rn == src))  return 2'b01;
    else if (m_w && (m_rn != 5'd0) && (m_rn == src))       return 2'b10;
    else                                                   return 2'b00;
  endfunction

  assign w_take  = exe_is_jump | (exe_is_beq & exe_zero) | (exe_is_bne & ~exe_zero);
  assign w_lu    = exe_wreg & exe_m2reg & (exe_rn != 5'd0) &
                   ((id_use_rs & (exe_rn == id_rs)) | (id_use_rt & (exe_rn == id_rt)));
  assign w_mwait = dmem_req & ~dmem_ack;
  // Once the watchdog expires the freeze is dropped even though memory is still busy.
  assign w_freeze = w_mwait & ((r_state == S_RUN) | (r_timer < TW'(TIMEOUT)));

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign wait_cnt  = r_wait_cnt;

  // Next-state and zero-latency stage controls
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    mem_wb_en     = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;
    w_state_nxt   = S_RUN;
    w_timer_nxt   = '0;
    w_mem_err_nxt = r_mem_err;
    w_inc_stall   = 1'b0;
    w_inc_flush   = 1'b0;
    w_inc_wait    = 1'b0;
    if (clrn) begin
      fwd_a = fwd_sel(id_rs, exe_wreg, exe_m2reg, exe_rn, mem_wreg, mem_rn);
      fwd_b = fwd_sel(id_rt, exe_wreg, exe_m2reg, exe_rn, mem_wreg, mem_rn);
      if (w_freeze) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_exe_en   = 1'b0;
        exe_mem_en  = 1'b0;
        mem_wb_en   = 1'b0;
        w_inc_wait  = 1'b1;
        w_state_nxt = S_MEM_WAIT;
        case (r_state)
          S_RUN:      w_timer_nxt = TW'(1);
          S_MEM_WAIT: w_timer_nxt = r_timer + TW'(1);
          default:    w_timer_nxt = TW'(1);
        endcase
      end else begin
        if (w_mwait) w_mem_err_nxt = 1'b1;
        else         w_mem_err_nxt = r_mem_err;
        // A taken branch squashes the ID instruction, so it overrides any load-use stall.
        if (w_take) begin
          pc_sel_branch = 1'b1;
          if_id_flush   = 1'b1;
          id_exe_bubble = 1'b1;
          w_inc_flush   = 1'b1;
        end else if (w_lu) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_exe_bubble = 1'b1;
          w_inc_stall   = 1'b1;
        end else begin
          pc_sel_branch = 1'b0;
        end
      end
    end else begin
      w_state_nxt = S_RUN;
    end
  end

  // State, watchdog timer, sticky error and saturating counters
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_RUN;
      r_timer     <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_mem_err   <= w_mem_err_nxt;
      r_stall_cnt <= sat_inc(r_stall_cnt, w_inc_stall);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_inc_flush);
      r_wait_cnt  <= sat_inc(r_wait_cnt, w_inc_wait);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed hazard scenarios plus randomized traffic compared
// every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, exe_rn = 5'd0, mem_rn = 5'd0;
  logic id_use_rs = 1'b0, id_use_rt = 1'b0, exe_wreg = 1'b0, exe_m2reg = 1'b0;
  logic exe_is_beq = 1'b0, exe_is_bne = 1'b0, exe_is_jump = 1'b0, exe_zero = 1'b0;
  logic mem_wreg = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic pc_sel_branch, if_id_flush, id_exe_bubble, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // model state: consecutive frozen cycles of the current memory wait, sticky error, event totals
  bit m_waiting;
  int m_frozen, m_stall, m_flush, m_wait;
  bit m_err;
  logic [11:0] obs_ctrl;
  int ack_div = 2;

  pipeline_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
    .exe_is_beq(exe_is_beq), .exe_is_bne(exe_is_bne), .exe_is_jump(exe_is_jump),
    .exe_zero(exe_zero), .mem_rn(mem_rn), .mem_wreg(mem_wreg), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en), .pc_sel_branch(pc_sel_branch),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [11:0] dut_ctrl();
    return {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
            pc_sel_branch, if_id_flush, id_exe_bubble, fwd_a, fwd_b};
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (exe_wreg && !exe_m2reg && exe_rn == src) return 2'b01;
    if (mem_wreg && mem_rn == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_idle();
    {id_rs, id_rt, exe_rn, mem_rn} = 20'd0;
    {id_use_rs, id_use_rt, exe_wreg, exe_m2reg} = 4'd0;
    {exe_is_beq, exe_is_bne, exe_is_jump, exe_zero, mem_wreg, dmem_req, dmem_ack} = 7'd0;
  endtask

  task automatic randomize_inputs();
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    exe_rn = 5'($urandom_range(0, 3));
    mem_rn = 5'($urandom_range(0, 3));
    id_use_rs = 1'($urandom_range(0, 1));
    id_use_rt = 1'($urandom_range(0, 1));
    exe_wreg = 1'($urandom_range(0, 1));
    exe_m2reg = 1'($urandom_range(0, 1));
    exe_is_beq = ($urandom_range(0, 7) == 0);
    exe_is_bne = ($urandom_range(0, 7) == 0);
    exe_is_jump = ($urandom_range(0, 11) == 0);
    exe_zero = 1'($urandom_range(0, 1));
    mem_wreg = 1'($urandom_range(0, 1));
    dmem_req = ($urandom_range(0, 2) == 0);
    dmem_ack = ($urandom_range(0, ack_div) == 0);
  endtask

  // One clock: inputs already applied; compare at the falling edge, then advance the model.
  task automatic step();
    bit take, lu, mw, frz;
    logic [7:0] act_bits;
    logic [11:0] exp_ctrl;
    @(negedge clk);
    #1;
    take = exe_is_jump || (exe_is_beq && exe_zero) || (exe_is_bne && !exe_zero);
    lu = exe_wreg && exe_m2reg && exe_rn != 5'd0 &&
         ((id_use_rs && exe_rn == id_rs) || (id_use_rt && exe_rn == id_rt));
    mw = dmem_req && !dmem_ack;
    frz = mw && (!m_waiting || m_frozen < TO);
    if (frz)       act_bits = 8'b00000_000;
    else if (take) act_bits = 8'b11111_111;
    else if (lu)   act_bits = 8'b00111_001;
    else           act_bits = 8'b11111_000;
    exp_ctrl = {act_bits, model_fwd(id_rs), model_fwd(id_rt)};
    obs_ctrl = dut_ctrl();
    check_eq("ctrl", 32'(obs_ctrl), 32'(exp_ctrl));
    check_eq("cnt", 32'({stall_cnt, flush_cnt, wait_cnt}),
             32'({m_stall[CW-1:0], m_flush[CW-1:0], m_wait[CW-1:0]}));
    check_eq("err", 32'(mem_err), 32'(m_err));
    if (frz) begin
      m_frozen++;
      m_waiting = 1'b1;
      if (m_wait < MAXC) m_wait++;
    end else begin
      if (mw) m_err = 1'b1;
      m_waiting = 1'b0;
      m_frozen = 0;
      if (take) begin
        if (m_flush < MAXC) m_flush++;
      end else if (lu) begin
        if (m_stall < MAXC) m_stall++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset with arbitrary inputs: controls must be quiescent immediately.
  task automatic do_reset();
    clrn = 1'b0;
    randomize_inputs();
    #1;
    check_eq("rst_ctrl", 32'(dut_ctrl()), 32'(12'b11111_000_0000));
    check_eq("rst_cnt", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);
    check_eq("rst_err", 32'(mem_err), 32'd0);
    m_waiting = 1'b0; m_frozen = 0; m_err = 1'b0;
    m_stall = 0; m_flush = 0; m_wait = 0;
    @(posedge clk);
    #1;
    set_idle();
    clrn = 1'b1;
  endtask

  initial begin
    set_idle();
    #2;
    do_reset();

    // load-use: lw r5 in EXE, ID reads r5
    exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    step();
    check_eq("lu_pc_en", 32'(obs_ctrl[11]), 32'd0);
    check_eq("lu_bubble", 32'(obs_ctrl[4]), 32'd1);
    exe_wreg = 1'b0; exe_m2reg = 1'b0; exe_rn = 5'd0; mem_wreg = 1'b1; mem_rn = 5'd5;
    step();
    check_eq("lu_release", 32'(obs_ctrl[11:7]), 32'h1f);
    check_eq("lu_fwd_mem", 32'(obs_ctrl[3:2]), 32'd2);
    check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // beq taken, then bne with zero=1 (not taken)
    do_reset();
    exe_is_beq = 1'b1; exe_zero = 1'b1;
    step();
    check_eq("beq_flush", 32'(obs_ctrl[6:4]), 32'd7);
    exe_is_beq = 1'b0; exe_is_bne = 1'b1;
    step();
    check_eq("bne_noflush", 32'(obs_ctrl[6:4]), 32'd0);
    check_eq("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // take and load-use together: flush only
    do_reset();
    exe_is_jump = 1'b1; exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_rn = 5'd3;
    id_rt = 5'd3; id_use_rt = 1'b1;
    step();
    check_eq("tl_ctrl", 32'(obs_ctrl[11:4]), 32'hff);
    set_idle();
    step();
    check_eq("tl_cnts", 32'({stall_cnt, flush_cnt}), 32'({4'd0, 4'd1}));

    // memory wait acked on the fourth cycle
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mw_freeze", 32'(obs_ctrl[11:7]), 32'd0);
    end
    dmem_ack = 1'b1;
    step();
    check_eq("mw_advance", 32'(obs_ctrl[11:7]), 32'h1f);
    set_idle();
    step();
    check_eq("mw_wait_cnt", 32'(wait_cnt), 32'd3);

    // watchdog: never acked
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    step();
    check_eq("to_release", 32'(obs_ctrl[11:7]), 32'h1f);
    set_idle();
    step();
    check_eq("to_err", 32'(mem_err), 32'd1);
    check_eq("to_wait_cnt", 32'(wait_cnt), 32'd4);

    // reset in the middle of a wait
    do_reset();
    dmem_req = 1'b1;
    step();
    step();
    do_reset();
    step();

    // forwarding priority and r0
    exe_wreg = 1'b1; exe_rn = 5'd7; mem_wreg = 1'b1; mem_rn = 5'd7; id_rs = 5'd7;
    step();
    check_eq("fwd_exe", 32'(obs_ctrl[3:2]), 32'd1);
    exe_rn = 5'd0; mem_rn = 5'd0; id_rt = 5'd0;
    step();
    check_eq("fwd_r0", 32'(obs_ctrl[1:0]), 32'd0);
    exe_wreg = 1'b0; mem_rn = 5'd7;
    step();
    check_eq("fwd_mem", 32'(obs_ctrl[3:2]), 32'd2);

    // randomized traffic with varying memory latency and occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 60 == 0) ack_div = (($urandom_range(0, 1) == 0) ? 1 : 12);
      if ($urandom_range(0, 249) == 0) do_reset();
      randomize_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Generates per-stage register enables, bubble and flush controls, and ID-stage operand forwarding selects.
- Covers three hazard sources: load-use, taken branch/jump resolved in EXE, and data-memory wait.
- Holds a small FSM for memory-wait sequencing with a watchdog, plus saturating event counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_cnt, flush_cnt and wait_cnt.
- TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before mem_err is raised.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- id_rs, id_rt  in  5 each  ID-stage source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs/rt
- exe_rn  in  5  EXE destination register
- exe_wreg, exe_m2reg  in  1 each  EXE writes reg / EXE is load
- exe_is_beq, exe_is_bne, exe_is_jump  in  1 each  EXE branch-type flags
- exe_zero  in  1  ALU zero flag in EXE
- mem_rn  in  5  MEM destination register
- mem_wreg  in  1  MEM writes reg
- dmem_req  in  1  MEM stage accessing data memory this cycle
- dmem_ack  in  1  data memory completes access
- pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1 each  stage register enables
- pc_sel_branch  out  1  PC loads EXE branch target (exe_bpc)
- if_id_flush  out  1  IF/ID loads NOP
- id_exe_bubble  out  1  ID/EXE loads all-zero controls
- fwd_a, fwd_b  out  2 each  ID operand source select: 00 regfile, 01 EXE ALU result, 10 MEM result
- mem_err  out  1  sticky watchdog error
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset: clk and clrn only. clrn low asynchronously forces state RUN, mem_err=0, all counters 0, and wait timer 0.
- Combinational outputs during reset: all enables 1, pc_sel_branch=0, if_id_flush=0, id_exe_bubble=0, fwd_a=fwd_b=00.
- Definitions:
  - take = exe_is_jump | (exe_is_beq & exe_zero) | (exe_is_bne & ~exe_zero).
  - lu = exe_wreg & exe_m2reg & exe_rn!=0 & ((id_use_rs & exe_rn==id_rs) | (id_use_rt & exe_rn==id_rt)).
  - mwait = dmem_req & ~dmem_ack.
- Control outputs are combinational from the registered state and current inputs; there is zero-cycle latency to the stage registers.
- RUN state, priority mwait > take > lu:
  - mwait: all five enables 0 (full freeze), no flush or bubble. Next state is MEM_WAIT; wait timer loads 1; wait_cnt++.
  - take: pc_sel_branch=1, if_id_flush=1, id_exe_bubble=1, all enables 1. flush_cnt++. Stay in RUN. Squashes exactly 2 younger instructions.
  - lu: pc_en=0, if_id_en=0, id_exe_bubble=1, exe_mem_en=mem_wb_en=1. stall_cnt++. Exactly 1 stall cycle per load-use.
  - Otherwise: all enables 1, no flush or bubble.
- MEM_WAIT state:
  - While mwait: full freeze, wait_cnt++, timer++.
  - If dmem_ack=1 or dmem_req=0: evaluate exactly as RUN for this cycle, excluding the mwait term. The pipeline advances and next state is RUN.
  - If the timer reaches TIMEOUT while still waiting: mem_err<=1 (sticky until reset), freeze is released this cycle with RUN-style evaluation, and next state is RUN.
- take and lu cannot both act in one cycle; take wins because the ID instruction is squashed anyway.
- Forwarding, per operand (rs to fwd_a, rt to fwd_b):
  - 01 if exe_wreg & ~exe_m2reg & exe_rn!=0 & exe_rn==src.
  - Else 10 if mem_wreg & mem_rn!=0 & mem_rn==src.
  - Else 00.
  - EXE has priority over MEM for the same register. Register 0 never forwards.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; no mem_err.

Test Plan:
- Reset, then lw r5 in EXE (exe_m2reg=1, exe_rn=5) with ID add reading rs=5: exactly 1 cycle of pc_en=0, if_id_en=0, id_exe_bubble=1, then all enables 1; stall_cnt=1.
- beq in EXE with exe_zero=1: pc_sel_branch=1, if_id_flush=1, id_exe_bubble=1 for one cycle; flush_cnt=1. Repeat with bne and exe_zero=1: no flush.
- Same-cycle take=1 and lu=1: flush action only; stall_cnt unchanged.
- dmem_req=1, ack after 3 cycles: all enables 0 for 3 cycles, advance on the ack cycle, wait_cnt=3, state RUN.
- dmem_req=1, never acked, TIMEOUT=4: freeze for 4 cycles, mem_err=1, pipeline released. clrn pulse clears mem_err and the counters.
- Forwarding with exe_rn=mem_rn=7, both writing, id_rs=7 gives fwd_a=01. With exe_rn=0 and id_rt=0: fwd_b=00. With only MEM matching: fwd=10.
